edge_sync_bank: RTL and testbench

Multi-channel synchronizer and edge-event monitor for asynchronous level inputs entering a single clock domain. Each channel passes its input through a parameterised flop chain, detects rising, falling or both edges per a runtime mode, and emits a single-cycle pulse. Each channel also keeps a saturating event counter and a sticky flag. The block is the generalised successor to the single-pulse toggle synchronizer, used wherever several external or foreign-domain signals must be converted into clean, counted events.

---
 rtl/edge_sync_pkg.sv | 14 +
 rtl/edge_sync_chan.sv | 98 +++++++++
 rtl/edge_sync_bank.sv | 62 ++++++
 tb/tb_edge_sync_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_sync_pkg.sv
// Shared types and limits for the edge_sync_bank synchronizer/edge-monitor slice.
package edge_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_CNT_W       = 1;

endpackage

// File: rtl/edge_sync_chan.sv
// One channel: synchronizer chain, optional debounce filter, edge detect, counter and sticky.
// Debounce is compiled in only when EDGE_SYNC_DEBOUNCE_EN is defined.
module edge_sync_chan
    import edge_sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             async_in,
    input  edge_mode_e       mode,
    input  logic             clr,
    input  logic             ready,
    output logic             pulse_out,
    output logic             sticky,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   lvl_c;
    logic                   rise_c;
    logic                   fall_c;
    logic                   event_c;

`ifdef EDGE_SYNC_DEBOUNCE_EN
    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic            filt_q;
    logic [DB_W-1:0] db_cnt_q;

    // Filtered level only follows the synchronized level after DB_CYCLES stable cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                filt_q   <= sync_q[SYNC_STAGES-1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign lvl_c = filt_q;
`else
    localparam int unsigned DB_CYCLES_UNUSED = DB_CYCLES;

    assign lvl_c = sync_q[SYNC_STAGES-1];
`endif

    // Edge qualification against the runtime mode, suppressed until warm-up completes
    always_comb begin
        event_c = 1'b0;
        rise_c  = lvl_c & ~hist_q;
        fall_c  = ~lvl_c & hist_q;
        case (mode)
            EDGE_RISE: event_c = rise_c;
            EDGE_FALL: event_c = fall_c;
            EDGE_BOTH: event_c = rise_c | fall_c;
            default:   event_c = 1'b0;
        endcase
        event_c = event_c & ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            pulse_out <= 1'b0;
            sticky    <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q    <= lvl_c;
            pulse_out <= event_c;
            // A clear that coincides with an event keeps that event
            if (clr) begin
                sticky  <= event_c;
                evt_cnt <= event_c ? CNT_W'(1) : '0;
            end else if (event_c) begin
                sticky <= 1'b1;
                if (evt_cnt != CNT_MAX) begin
                    evt_cnt <= evt_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/edge_sync_bank.sv
// Multi-channel synchronizer and edge-event monitor with shared warm-up gating.
// Optional per-channel debounce filter: define EDGE_SYNC_DEBOUNCE_EN.
module edge_sync_bank
    import edge_sync_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       async_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       pulse_out,
    output logic [CH-1:0]       sticky,
    output logic [CH*CNT_W-1:0] evt_cnt,
    output logic                ready
);

    localparam int unsigned WU_W = $clog2(SYNC_STAGES + 1) + 1;

    logic [WU_W-1:0] wu_cnt_q;

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("edge_sync_bank: SYNC_STAGES below minimum");
    end
    if (CNT_W < MIN_CNT_W) begin : g_bad_cnt
        $error("edge_sync_bank: CNT_W below minimum");
    end

    // Warm-up: ready rises SYNC_STAGES+1 cycles after reset release and holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wu_cnt_q <= '0;
            ready    <= 1'b0;
        end else if (!ready) begin
            wu_cnt_q <= wu_cnt_q + WU_W'(1);
            ready    <= (wu_cnt_q == WU_W'(SYNC_STAGES));
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_sync_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .DB_CYCLES   (DB_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .async_in  (async_in[i]),
            .mode      (edge_mode_e'(mode[2*i +: 2])),
            .clr       (clr[i]),
            .ready     (ready),
            .pulse_out (pulse_out[i]),
            .sticky    (sticky[i]),
            .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_sync_bank.sv
// Directed bench for edge_sync_bank (default build, debounce not compiled in).
module tb_edge_sync_bank;

    localparam int unsigned CH = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  async_in;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  pulse_out;
    logic [3:0]  sticky;
    logic [31:0] evt_cnt;
    logic        ready;
    logic [3:0]  pulse_s;
    logic [3:0]  sticky_s;
    logic [7:0]  evt_cnt_s;
    logic        ready_s;

    int n_tests = 0;
    int n_fail  = 0;

    edge_sync_bank #(.CH(CH), .SYNC_STAGES(2), .CNT_W(8), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .mode(mode), .clr(clr),
        .pulse_out(pulse_out), .sticky(sticky), .evt_cnt(evt_cnt), .ready(ready)
    );

    edge_sync_bank #(.CH(CH), .SYNC_STAGES(2), .CNT_W(2), .DB_CYCLES(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .mode(mode), .clr(clr),
        .pulse_out(pulse_s), .sticky(sticky_s), .evt_cnt(evt_cnt_s), .ready(ready_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] in;
        logic [7:0] md;
        logic [3:0] cl;
        logic [3:0] exp_pulse;
        logic [7:0] exp_cnt0;
        logic       exp_sticky0;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int  pulses;
        bit  dbl;
        logic prev;

        vecs[0] = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 8'd0, 1'b0};
        vecs[1] = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 8'd0, 1'b0};
        vecs[2] = '{4'b0001, 8'h55, 4'b0000, 4'b0001, 8'd1, 1'b1};
        vecs[3] = '{4'b0001, 8'h55, 4'b0000, 4'b0000, 8'd1, 1'b1};
        vecs[4] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 8'd1, 1'b1};
        vecs[5] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 8'd1, 1'b1};
        vecs[6] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 8'd1, 1'b1};
        vecs[7] = '{4'b0000, 8'h55, 4'b0000, 4'b0000, 8'd1, 1'b1};

        // Reset with all inputs already high
        rst_n    = 1'b0;
        async_in = 4'hF;
        mode     = 8'h55;
        clr      = 4'h0;
        tick();
        tick();
        check("rst_pulse", 32'(pulse_out), 32'h0);
        check("rst_sticky", 32'(sticky), 32'h0);
        check("rst_cnt", evt_cnt, 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("warm_ready_%0d", k), 32'(ready), 32'((k >= 3) ? 1 : 0));
            check($sformatf("warm_pulse_%0d", k), 32'(pulse_out), 32'h0);
        end
        check("warm_cnt", evt_cnt, 32'h0);
        async_in = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fall_in_rise_mode", 32'(pulse_out), 32'h0);
        end

        // Channel 0 rising-edge latency table
        for (int v = 0; v < 8; v++) begin
            async_in = vecs[v].in;
            mode     = vecs[v].md;
            clr      = vecs[v].cl;
            tick();
            check($sformatf("vec%0d_pulse", v), 32'(pulse_out), 32'(vecs[v].exp_pulse));
            check($sformatf("vec%0d_cnt0", v), 32'(evt_cnt[7:0]), 32'(vecs[v].exp_cnt0));
            check($sformatf("vec%0d_sticky0", v), 32'(sticky[0]), 32'(vecs[v].exp_sticky0));
        end

        // Channel 2 both-edge mode: four changes, four pulses
        mode   = 8'h75;
        pulses = 0;
        dbl    = 1'b0;
        prev   = 1'b0;
        for (int j = 0; j < 4; j++) begin
            async_in[2] = ~async_in[2];
            for (int k = 0; k < 3; k++) begin
                tick();
                if (pulse_out[2]) pulses++;
                if (pulse_out[2] && prev) dbl = 1'b1;
                prev = pulse_out[2];
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (pulse_out[2]) pulses++;
        end
        check("ch2_pulses", 32'(pulses), 32'd4);
        check("ch2_single_cycle", 32'(dbl), 32'd0);
        check("ch2_cnt", 32'(evt_cnt[23:16]), 32'd4);
        check("ch2_sticky", 32'(sticky[2]), 32'd1);

        // Channel 2 mode off: toggles ignored
        mode   = 8'h45;
        pulses = 0;
        for (int j = 0; j < 2; j++) begin
            async_in[2] = ~async_in[2];
            for (int k = 0; k < 3; k++) begin
                tick();
                if (pulse_out[2]) pulses++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (pulse_out[2]) pulses++;
        end
        check("ch2_off_pulses", 32'(pulses), 32'd0);
        check("ch2_off_cnt", 32'(evt_cnt[23:16]), 32'd4);

        // Channel 1: five rising events, saturation in the 2-bit instance
        mode   = 8'h55;
        pulses = 0;
        for (int j = 0; j < 5; j++) begin
            async_in[1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (pulse_out[1]) pulses++;
            end
            async_in[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (pulse_out[1]) pulses++;
            end
        end
        check("ch1_pulses", 32'(pulses), 32'd5);
        check("ch1_cnt8", 32'(evt_cnt[15:8]), 32'd5);
        check("ch1_cnt2_sat", 32'(evt_cnt_s[3:2]), 32'd3);
        check("ch1_sticky_s", 32'(sticky_s[1]), 32'd1);
        clr = 4'b0010;
        tick();
        clr = 4'b0000;
        check("clr_cnt8", 32'(evt_cnt[15:8]), 32'd0);
        check("clr_cnt2", 32'(evt_cnt_s[3:2]), 32'd0);
        check("clr_sticky", 32'(sticky[1]), 32'd0);
        check("clr_sticky_s", 32'(sticky_s[1]), 32'd0);
        check("clr_other_ch", 32'(evt_cnt[23:16]), 32'd4);

        // Clear coinciding with an event keeps the event
        async_in[1] = 1'b1;
        tick();
        tick();
        clr = 4'b0010;
        tick();
        clr = 4'b0000;
        check("clr_evt_pulse", 32'(pulse_out[1]), 32'd1);
        check("clr_evt_cnt", 32'(evt_cnt[15:8]), 32'd1);
        check("clr_evt_sticky", 32'(sticky[1]), 32'd1);
        check("clr_evt_cnt_s", 32'(evt_cnt_s[3:2]), 32'd1);
        tick();
        check("clr_evt_pulse_end", 32'(pulse_out[1]), 32'd0);
        async_in[1] = 1'b0;
        repeat (4) tick();

        // Reset with an edge in flight on channel 0
        async_in[0] = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_pulse", 32'(pulse_out), 32'h0);
        check("mid_rst_cnt", evt_cnt, 32'h0);
        check("mid_rst_sticky", 32'(sticky), 32'h0);
        check("mid_rst_ready", 32'(ready), 32'h0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pulse_out != 4'h0) pulses++;
        end
        check("mid_rst_no_pulse", 32'(pulses), 32'd0);
        check("mid_rst_ready_back", 32'(ready), 32'd1);
        check("mid_rst_cnt_after", evt_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
